mips_mem_arbiter: RTL and testbench

- Shares one memory bus with wait-request between two requesters: the CPU instruction-fetch port (read-only) and the CPU data port (read/write).
- Sits between mips_cpu core ports and a single-ported RAM/bus model.
- Sequences one transaction at a time with a registered state machine and round-robin arbitration.
- Provides a per-requester completion pulse, and a timeout abort so a hung bus cannot lock up the CPU.

---
 rtl/mips_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - round-robin arbiter sharing one wait-request memory bus
// between the CPU instruction-fetch port and data port, with timeout abort.
module mips_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_done,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byteen,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                err,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic                mem_waitrequest,
   input  logic [DATA_W-1:0]   mem_readdata
);
   localparam int BE_W = DATA_W / 8;
   localparam int TCW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCW-1:0] TLIM = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [TCW-1:0]    tcnt_q, tcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              i_elig, d_elig;

   // A requester still showing its done pulse is masked so it cannot be re-granted on a stale request.
   assign i_elig = i_req & ~i_done_q;
   assign d_elig = (d_read | d_write) & ~d_done_q;

   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      tcnt_d    = tcnt_q;
      addr_d    = addr_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      i_done_d  = 1'b0;
      d_done_d  = 1'b0;
      err_d     = 1'b0;
      i_rdata_d = '0;
      d_rdata_d = '0;
      case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (i_elig && (!d_elig || last_d_q)) begin
               addr_d   = i_addr;
               rd_d     = 1'b1;
               wr_d     = 1'b0;
               wdata_d  = '0;
               be_d     = '1;
               last_d_d = 1'b0;
               state_d  = BUSY_I;
            end else if (d_elig) begin
               addr_d   = d_addr;
               rd_d     = ~d_write;
               wr_d     = d_write;
               wdata_d  = d_write ? d_wdata : '0;
               be_d     = d_write ? d_byteen : '1;
               last_d_d = 1'b1;
               state_d  = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (!mem_waitrequest || (TIMEOUT != 0 && tcnt_q == TLIM)) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               err_d   = mem_waitrequest;
               state_d = IDLE;
               if (state_q == BUSY_I) begin
                  i_done_d  = 1'b1;
                  i_rdata_d = mem_waitrequest ? '0 : mem_readdata;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = (mem_waitrequest || !rd_q) ? '0 : mem_readdata;
               end
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         last_d_q  <= 1'b1;
         tcnt_q    <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         be_q      <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         tcnt_q    <= tcnt_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         err_q     <= err_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign mem_address    = addr_q;
   assign mem_read       = rd_q;
   assign mem_write      = wr_q;
   assign mem_writedata  = wdata_q;
   assign mem_byteenable = be_q;
   assign i_done         = i_done_q;
   assign d_done         = d_done_q;
   assign err            = err_q;
   assign i_rdata        = i_rdata_q;
   assign d_rdata        = d_rdata_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - table-driven self-checking bench for mips_mem_arbiter
module tb_mips_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_read, d_write, mem_waitrequest;
   logic [31:0] i_addr, d_addr, d_wdata, mem_readdata;
   logic [3:0]  d_byteen;
   logic [31:0] i_rdata, d_rdata, mem_address, mem_writedata;
   logic        i_done, d_done, err, mem_read, mem_write;
   logic [3:0]  mem_byteenable;

   int checks = 0;
   int errors = 0;

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteen(d_byteen), .d_rdata(d_rdata), .d_done(d_done), .err(err),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          waits;
      logic [31:0] mem_rd;
      logic        exp_wr;
      logic [3:0]  exp_be;
      int          exp_strobes;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drop_reqs();
      i_req = 0; d_read = 0; d_write = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; d_byteen = 0;
   endtask

   // Entered on a negedge; returns on a negedge one cycle after the done pulse.
   task automatic run_vec(input int idx, input vec_t v);
      int sc;
      logic done_seen;
      logic [69:0] snap;
      i_req = !v.is_d;
      i_addr = v.is_d ? 32'h0 : v.addr;
      d_read = v.is_d & v.rd;
      d_write = v.is_d & v.wr;
      d_addr = v.is_d ? v.addr : 32'h0;
      d_wdata = v.wdata;
      d_byteen = v.be;
      mem_readdata = v.mem_rd;
      mem_waitrequest = 0;
      sc = 0;
      done_seen = 0;
      snap = '0;
      for (int c = 1; c <= 40 && !done_seen; c++) begin
         @(negedge clk);
         if (mem_read && mem_write) chk($sformatf("v%0d_two_strobes", idx), 1, 0);
         if (mem_read || mem_write) begin
            sc++;
            if (sc == 1) begin
               chk($sformatf("v%0d_latency", idx), c, 1);
               chk($sformatf("v%0d_addr", idx), mem_address, v.addr);
               chk($sformatf("v%0d_write", idx), mem_write, v.exp_wr);
               chk($sformatf("v%0d_be", idx), mem_byteenable, v.exp_be);
               if (v.exp_wr) chk($sformatf("v%0d_wdata", idx), mem_writedata, v.wdata);
               snap = {mem_address, mem_writedata, mem_byteenable, mem_read, mem_write};
            end else begin
               chk($sformatf("v%0d_stable", idx),
                   ({mem_address, mem_writedata, mem_byteenable, mem_read, mem_write} == snap), 1);
            end
            mem_waitrequest = (sc <= v.waits);
         end else begin
            mem_waitrequest = 0;
         end
         if (i_done || d_done) begin
            done_seen = 1;
            chk($sformatf("v%0d_done_sel", idx), {i_done, d_done}, v.is_d ? 2'b01 : 2'b10);
            chk($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
            chk($sformatf("v%0d_err", idx), err, v.exp_err);
            chk($sformatf("v%0d_strobe_cycles", idx), sc, v.exp_strobes);
            drop_reqs();
         end
      end
      chk($sformatf("v%0d_done_seen", idx), done_seen, 1);
      @(negedge clk);
      chk($sformatf("v%0d_after_done", idx), {i_done, d_done, err, mem_read, mem_write}, 0);
      chk($sformatf("v%0d_rdata_cleared", idx), i_rdata | d_rdata, 0);
   endtask

   initial begin
      //             is_d rd wr addr           wdata          be    waits mem_rd         exp_wr exp_be st exp_rdata     err
      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'h0, 0,   32'h24020005, 1'b0, 4'hF, 1, 32'h24020005, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h00000100, 32'hDEADBEEF, 4'h3, 3,   32'h12345678, 1'b1, 4'h3, 4, 32'h0,        1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00000200, 32'h0,        4'h5, 2,   32'hCAFEF00D, 1'b0, 4'hF, 3, 32'hCAFEF00D, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h00000300, 32'h0,        4'hF, 100, 32'h77777777, 1'b0, 4'hF, 8, 32'h0,        1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h00000400, 32'h0,        4'h0, 1,   32'h0BADC0DE, 1'b0, 4'hF, 2, 32'h0BADC0DE, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h00000500, 32'h55AA55AA, 4'hC, 0,   32'h99999999, 1'b1, 4'hC, 1, 32'h0,        1'b0};

      reset = 0;
      drop_reqs();
      mem_waitrequest = 0;
      mem_readdata = 0;
      #12;
      chk("reset_strobes", {mem_read, mem_write, i_done, d_done, err}, 0);
      chk("reset_addr", mem_address, 0);
      chk("reset_rdata", i_rdata | d_rdata | mem_writedata, 0);
      @(negedge clk);
      reset = 1;

      for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

      // Asynchronous reset in the middle of a stalled data write.
      d_write = 1; d_addr = 32'h600; d_wdata = 32'h01020304; d_byteen = 4'hF;
      mem_waitrequest = 1;
      repeat (3) @(negedge clk);
      chk("midrst_strobe_before", mem_write, 1);
      #2 reset = 0;
      #1;
      chk("midrst_strobe_async", {mem_read, mem_write}, 0);
      @(negedge clk);
      drop_reqs();
      mem_waitrequest = 0;
      reset = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("midrst_no_done", {d_done, i_done, mem_read, mem_write}, 0);
      end

      // Round-robin: both requesters held; grants must alternate I, D, I, D.
      begin
         int g;
         int last_c;
         logic [3:0] order;
         g = 0; last_c = 0; order = 0;
         i_req = 1; i_addr = 32'h1000; d_read = 1; d_addr = 32'h2000;
         mem_waitrequest = 0;
         mem_readdata = 32'hA5A5A5A5;
         for (int c = 1; c <= 40 && g < 4; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) chk("rr_two_strobes", 1, 0);
            if ((i_done || d_done) && (mem_read || mem_write)) chk("rr_no_idle_gap", 1, 0);
            if (mem_read || mem_write) begin
               order[g] = (mem_address == 32'h2000);
               if (g > 0) chk($sformatf("rr_spacing_%0d", g), c - last_c, 2);
               last_c = c;
               g++;
               if (g == 4) i_req = 0;
            end
         end
         chk("rr_grant_count", g, 4);
         chk("rr_order", order, 4'b1010);
         for (int c = 0; c < 5 && d_read; c++) begin
            @(negedge clk);
            if (d_done) begin
               chk("rr_last_rdata", d_rdata, 32'hA5A5A5A5);
               drop_reqs();
            end
         end
         chk("rr_final_done", d_read, 0);
         @(negedge clk);
         chk("rr_quiet", {mem_read, mem_write, i_done, d_done}, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
